// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART frame transmit path.
//   tx_ctrl_state_t     : sequencer state encoding
//   SYNC0/SYNC1_DEFAULT : default packet sync header bytes
//   FRAME_BYTES_DEFAULT : packed pixel bytes per captured frame
package uart_tx_pkg;

  localparam logic [7:0]  SYNC0_DEFAULT       = 8'hAA;
  localparam logic [7:0]  SYNC1_DEFAULT       = 8'h55;
  localparam int unsigned FRAME_BYTES_DEFAULT = 5160;

  typedef enum logic [3:0] {
    IDLE,
    HDR0,
    HDR1,
    LENH,
    LENL,
    PIX_RD,
    PIX_WR,
    CSUM,
    DONE
  } tx_ctrl_state_t;

endpackage

// File: rtl/uart_frame_tx_ctrl_if.sv
// Frame RAM read port plus UART TX FIFO write port of the frame sequencer.
//   ram_re / ram_addr   : RAM read request (master -> slave)
//   ram_rdata           : RAM read data, one cycle after ram_re (slave -> master)
//   fifo_full           : TX FIFO full (slave -> master)
//   fifo_push/fifo_wdata: TX FIFO write strobe and byte (master -> slave)
// The master modport is the sequencer; the slave modport is the RAM/FIFO side.
interface uart_frame_tx_ctrl_if #(
  parameter int ADDR_W = 13
);
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_rdata;
  logic              fifo_full;
  logic              fifo_push;
  logic [7:0]        fifo_wdata;

  modport master (
    output ram_re, ram_addr, fifo_push, fifo_wdata,
    input  ram_rdata, fifo_full
  );

  modport slave (
    input  ram_re, ram_addr, fifo_push, fifo_wdata,
    output ram_rdata, fifo_full
  );
endinterface

// File: rtl/tx_csum_acc.sv
// 8-bit modulo-256 byte accumulator (carry discarded) with clear and enable.
//   clk, reset : clock, synchronous active-high reset
//   i_clr      : synchronous clear (wins over i_en)
//   i_en       : add i_din this cycle
//   i_din      : byte to accumulate
//   o_sum      : running sum
module tx_csum_acc (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_din,
  output logic [7:0] o_sum
);
  logic [7:0] r_sum;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_sum <= '0;
    end else if (i_en) begin
      r_sum <= r_sum + i_din;
    end
  end

  assign o_sum = r_sum;
endmodule

// File: rtl/uart_frame_tx_ctrl.sv
// Frame packet sequencer: streams one frame from the TX frame RAM into the
// UART TX FIFO as SYNC0, SYNC1, LEN[15:8], LEN[7:0], pixel bytes and, when
// TX_CHECKSUM_EN is defined, a trailing 8-bit sum of the pixel bytes.
// RAM reads are issued only while the FIFO has room, so the byte returned
// one cycle later can always be pushed.
//   clk, reset   : clock, synchronous active-high reset
//   i_frame_tick : a complete frame is in RAM (accepted only in IDLE)
//   bus          : RAM read / FIFO write port (master side)
//   o_busy       : packet in progress (cycle after accepted tick through DONE)
//   o_frame_done : one-cycle pulse after the last byte is pushed
//   o_overrun    : sticky; tick arrived while busy, cleared by next accepted tick
// Build option: TX_CHECKSUM_EN adds the checksum byte and its accumulator.
module uart_frame_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = FRAME_BYTES_DEFAULT,
  parameter logic [7:0]  SYNC0       = SYNC0_DEFAULT,
  parameter logic [7:0]  SYNC1       = SYNC1_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_frame_tick,
  uart_frame_tx_ctrl_if.master bus,
  output logic                 o_busy,
  output logic                 o_frame_done,
  output logic                 o_overrun
);
  localparam int ADDR_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [15:0]       LEN       = 16'(FRAME_BYTES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);

  tx_ctrl_state_t    r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_overrun;
  logic              w_accept;
  logic              w_push;
  logic              w_ram_re;
  logic [7:0]        w_byte;

  assign w_accept = (r_state == IDLE) && i_frame_tick;

`ifdef TX_CHECKSUM_EN
  logic [7:0] w_csum;

  tx_csum_acc u_csum (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_accept),
    .i_en  (r_state == PIX_WR),
    .i_din (bus.ram_rdata),
    .o_sum (w_csum)
  );
`endif

  // Push/read strobes follow fifo_full combinationally so a stalled state
  // retries every cycle. PIX_WR pushes unconditionally: the FIFO had room
  // when the read was issued and nobody else can fill it in between.
  always_comb begin
    w_push   = 1'b0;
    w_ram_re = 1'b0;
    w_byte   = 8'h00;
    case (r_state)
      HDR0:   begin w_push = ~bus.fifo_full; w_byte = SYNC0;     end
      HDR1:   begin w_push = ~bus.fifo_full; w_byte = SYNC1;     end
      LENH:   begin w_push = ~bus.fifo_full; w_byte = LEN[15:8]; end
      LENL:   begin w_push = ~bus.fifo_full; w_byte = LEN[7:0];  end
      PIX_RD: w_ram_re = ~bus.fifo_full;
      PIX_WR: begin w_push = 1'b1; w_byte = bus.ram_rdata; end
`ifdef TX_CHECKSUM_EN
      CSUM:   begin w_push = ~bus.fifo_full; w_byte = w_csum; end
`endif
      default: ;
    endcase
  end

  assign bus.fifo_push  = w_push;
  assign bus.fifo_wdata = w_push ? w_byte : 8'h00;
  assign bus.ram_re     = w_ram_re;
  assign bus.ram_addr   = (r_state == PIX_RD) ? r_cnt : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_overrun <= 1'b0;
    end else begin
      // A tick in IDLE clears overrun; a tick anywhere else (DONE included) sets it.
      if (i_frame_tick) r_overrun <= (r_state != IDLE);
      case (r_state)
        IDLE: if (w_accept) begin
          r_cnt   <= '0;
          r_state <= HDR0;
        end
        HDR0:   if (w_push)   r_state <= HDR1;
        HDR1:   if (w_push)   r_state <= LENH;
        LENH:   if (w_push)   r_state <= LENL;
        LENL:   if (w_push)   r_state <= PIX_RD;
        PIX_RD: if (w_ram_re) r_state <= PIX_WR;
        PIX_WR: begin
          if (r_cnt == LAST_ADDR) begin
`ifdef TX_CHECKSUM_EN
            r_state <= CSUM;
`else
            r_state <= DONE;
`endif
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= PIX_RD;
          end
        end
`ifdef TX_CHECKSUM_EN
        CSUM:   if (w_push) r_state <= DONE;
`endif
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy       = (r_state != IDLE);
  assign o_frame_done = (r_state == DONE);
  assign o_overrun    = r_overrun;
endmodule

// File: tb/tb_uart_frame_tx_ctrl.sv
module tb_uart_frame_tx_ctrl;
  localparam int FB = 4;
`ifdef TX_CHECKSUM_EN
  localparam bit HAS_CSUM = 1'b1;
  localparam int DONE_OFF = 14;
`else
  localparam bit HAS_CSUM = 1'b0;
  localparam int DONE_OFF = 13;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_tick = 1'b0;
  logic busy, frame_done, overrun;

  uart_frame_tx_ctrl_if #(.ADDR_W(2)) bus ();

  uart_frame_tx_ctrl #(.FRAME_BYTES(FB)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_frame_tick (frame_tick),
    .bus          (bus),
    .o_busy       (busy),
    .o_frame_done (frame_done),
    .o_overrun    (overrun)
  );

  always #5 clk = ~clk;

  logic [7:0] mem     [FB];
  logic [7:0] exp_pix [FB];

  always @(posedge clk) if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_addr];

  int cyc = 0;
  int tick_cyc = 0;
  int done_n = 0;
  int done_cyc = 0;
  int bad_full = 0;
  logic [7:0] got[$];
  int gotc[$];
  int addrs[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      if (frame_tick && !busy) tick_cyc <= cyc;
      if (bus.fifo_push) begin
        got.push_back(bus.fifo_wdata);
        gotc.push_back(cyc);
      end
      if (bus.ram_re) addrs.push_back(int'(bus.ram_addr));
      if (frame_done) begin
        done_n   <= done_n + 1;
        done_cyc <= cyc;
      end
      if (bus.fifo_full && (bus.fifo_push || bus.ram_re)) bad_full <= bad_full + 1;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic tk();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ram_re"}, bus.ram_re, 0);
    chk({tag, "_ram_addr"}, bus.ram_addr, 0);
    chk({tag, "_push"}, bus.fifo_push, 0);
    chk({tag, "_wdata"}, bus.fifo_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  // Advance until frame_done is observed (bounded); optionally step past DONE.
  task automatic wait_done(input string tag, input bit step_out);
    int n = 0;
    while (frame_done !== 1'b1 && n < 200) begin
      tk();
      n++;
    end
    chk({tag, "_done_seen"}, frame_done, 1);
    if (step_out) tk();
  endtask

  task automatic check_pkt(input string tag, input int g0, input int d0, input logic [7:0] csum);
    logic [7:0] e[$];
    e = '{8'hAA, 8'h55, 8'h00, 8'h04};
    for (int i = 0; i < FB; i++) e.push_back(exp_pix[i]);
    if (HAS_CSUM) e.push_back(csum);
    chk({tag, "_len"}, got.size() - g0, e.size());
    for (int i = 0; i < e.size() && g0 + i < got.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), got[g0 + i], e[i]);
    if (got.size() > g0) begin
      chk({tag, "_sync0_cyc"}, gotc[g0] - tick_cyc, 1);
      chk({tag, "_done_after_last"}, done_cyc - gotc[got.size() - 1], 1);
    end else begin
      chk({tag, "_any_push"}, got.size() - g0, e.size());
    end
    chk({tag, "_done_pulses"}, done_n - d0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, d0, a0, b0;
    bus.fifo_full = 1'b0;
    reset = 1'b1;
    tk();
    tk();
    chk_idle_outputs("rst");
    reset = 1'b0;
    tk();

    // Test 1: plain frame 01..04, FIFO never full
    mem = '{8'h01, 8'h02, 8'h03, 8'h04};
    exp_pix = '{8'h01, 8'h02, 8'h03, 8'h04};
    g0 = got.size(); d0 = done_n; a0 = addrs.size(); b0 = bad_full;
    frame_tick = 1'b1;
    tk();
    frame_tick = 1'b0;
    chk("t1_busy_after_tick", busy, 1);
    wait_done("t1", 1'b1);
    check_pkt("t1", g0, d0, 8'h0A);
    chk("t1_addr_n", addrs.size() - a0, 4);
    for (int i = 0; i < 4 && a0 + i < addrs.size(); i++)
      chk($sformatf("t1_addr%0d", i), addrs[a0 + i], i);
    chk("t1_done_cyc", done_cyc - tick_cyc, DONE_OFF);
    chk("t1_idle_busy", busy, 0);

    // Test 2: FIFO full for 3 cycles while in HDR1
    g0 = got.size(); d0 = done_n; b0 = bad_full;
    frame_tick = 1'b1;
    tk();
    frame_tick = 1'b0;
    tk();
    bus.fifo_full = 1'b1;
    #1;
    chk("t2_stall_push", bus.fifo_push, 0);
    chk("t2_stall_wdata", bus.fifo_wdata, 0);
    tk();
    tk();
    tk();
    bus.fifo_full = 1'b0;
    wait_done("t2", 1'b1);
    check_pkt("t2", g0, d0, 8'h0A);
    if (got.size() > g0 + 1) chk("t2_hdr1_cyc", gotc[g0 + 1] - tick_cyc, 5);
    else chk("t2_hdr1_present", got.size() - g0, 2);
    chk("t2_done_cyc", done_cyc - tick_cyc, DONE_OFF + 3);
    chk("t2_no_push_full", bad_full - b0, 0);

    // Test 3: FIFO full for 2 cycles during PIX_RD of address 2
    g0 = got.size(); d0 = done_n; a0 = addrs.size(); b0 = bad_full;
    frame_tick = 1'b1;
    tk();
    frame_tick = 1'b0;
    for (int i = 0; i < 8; i++) tk();
    bus.fifo_full = 1'b1;
    #1;
    chk("t3_stall_ram_re", bus.ram_re, 0);
    chk("t3_stall_push", bus.fifo_push, 0);
    chk("t3_stall_addr", bus.ram_addr, 2);
    tk();
    tk();
    bus.fifo_full = 1'b0;
    wait_done("t3", 1'b1);
    check_pkt("t3", g0, d0, 8'h0A);
    chk("t3_addr_n", addrs.size() - a0, 4);
    for (int i = 0; i < 4 && a0 + i < addrs.size(); i++)
      chk($sformatf("t3_addr%0d", i), addrs[a0 + i], i);
    chk("t3_done_cyc", done_cyc - tick_cyc, DONE_OFF + 2);
    chk("t3_no_re_full", bad_full - b0, 0);

    // Test 4: second tick mid-pixel, then clear, then tick during DONE
    g0 = got.size(); d0 = done_n;
    frame_tick = 1'b1;
    tk();
    frame_tick = 1'b0;
    for (int i = 0; i < 6; i++) tk();
    frame_tick = 1'b1;
    tk();
    frame_tick = 1'b0;
    chk("t4_overrun_set", overrun, 1);
    chk("t4_still_busy", busy, 1);
    wait_done("t4", 1'b1);
    check_pkt("t4", g0, d0, 8'h0A);
    chk("t4_done_cyc", done_cyc - tick_cyc, DONE_OFF);
    chk("t4_overrun_sticky", overrun, 1);
    g0 = got.size(); d0 = done_n;
    frame_tick = 1'b1;
    tk();
    frame_tick = 1'b0;
    chk("t4_overrun_cleared", overrun, 0);
    wait_done("t4b", 1'b0);
    frame_tick = 1'b1;
    tk();
    frame_tick = 1'b0;
    chk("t4_done_tick_overrun", overrun, 1);
    chk("t4_done_tick_not_taken", busy, 0);
    tk();
    chk("t4_no_restart_busy", busy, 0);
    chk("t4_no_restart_push", bus.fifo_push, 0);
    check_pkt("t4b", g0, d0, 8'h0A);

    // Test 5: reset in PIX_WR, then fresh frame of FF bytes
    mem = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    exp_pix = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    frame_tick = 1'b1;
    tk();
    frame_tick = 1'b0;
    for (int i = 0; i < 5; i++) tk();
    chk("t5_in_pix_wr_push", bus.fifo_push, 1);
    reset = 1'b1;
    tk();
    reset = 1'b0;
    chk_idle_outputs("t5_rst");
    g0 = got.size(); d0 = done_n;
    frame_tick = 1'b1;
    tk();
    frame_tick = 1'b0;
    wait_done("t5", 1'b1);
    check_pkt("t5", g0, d0, 8'hFC);
    chk("t5_done_cyc", done_cyc - tick_cyc, DONE_OFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_frame_tx_ctrl.md
# uart_frame_tx_ctrl

Sequences one captured edge-map frame out of the TX frame RAM into the UART TX FIFO as a framed packet: sync header, 16-bit length, pixel bytes and an optional checksum. It sits between the pixel-packing/frame RAM stage and `uart_tx_fifo`, and is the only writer of that FIFO. It issues RAM reads only when the FIFO can accept the resulting byte, so no data is lost under back-pressure.

## Interface
- `FRAME_BYTES`, 5160: packed pixel bytes per frame; RAM addresses 0..FRAME_BYTES-1; must be ≤ 65535.
- `SYNC0`, 8'hAA: first header byte.
- `SYNC1`, 8'h55: second header byte.
- `clk`  in  1: the single clock.
- `reset`  in  1: synchronous, active-high.
- `frame_tick`  in  1: one-cycle pulse; a complete frame is in RAM.
- `ram_re`  out  1: RAM read enable.
- `ram_addr`  out  $clog2(FRAME_BYTES): RAM read address.
- `ram_rdata`  in  8: RAM read data, valid exactly 1 cycle after `ram_re`.
- `fifo_full`  in  1: TX FIFO full.
- `fifo_push`  out  1: FIFO write strobe.
- `fifo_wdata`  out  8: FIFO write data.
- `busy`  out  1: high from the cycle after an accepted `frame_tick` through the DONE state.
- `frame_done`  out  1: one-cycle pulse after the last byte is pushed.
- `overrun`  out  1: sticky; set by `frame_tick` while busy, cleared by the next accepted `frame_tick`.

## Operation
- States: IDLE → HDR0 → HDR1 → LENH → LENL → PIX_RD ⇄ PIX_WR → CSUM → DONE → IDLE.
- IDLE: `frame_tick` is accepted. The byte counter and checksum clear, and the state moves to HDR0.
- HDR0, HDR1, LENH, LENL:
  - `fifo_push` = ~`fifo_full` (combinational).
  - `fifo_wdata` = SYNC0, SYNC1, FRAME_BYTES[15:8], FRAME_BYTES[7:0] respectively.
  - The state advances only on a push.
- PIX_RD:
  - `ram_re` = ~`fifo_full` and `ram_addr` = counter.
  - If `ram_re` is high, go to PIX_WR; otherwise stay.
- PIX_WR:
  - Unconditional `fifo_push`, with `fifo_wdata` = `ram_rdata`.
  - This is safe because this block is the only pusher, so `fifo_full` cannot rise in between.
  - The checksum accumulates `ram_rdata`.
  - If counter == FRAME_BYTES-1, go to CSUM; otherwise increment the counter and return to PIX_RD.
- CSUM: `fifo_push` = ~`fifo_full` and `fifo_wdata` = checksum. The state advances on a push.
- DONE: `frame_done` = 1 for exactly one cycle, then IDLE.
- Checksum: 8-bit, the sum of the pixel bytes modulo 256 (carry discarded). It excludes the header and length bytes.
- Counter width: $clog2(FRAME_BYTES). No wrap-around is reachable, because the terminal compare ends PIX.
- `frame_tick` while not in IDLE: ignored for sequencing and sets `overrun`. The frame in progress completes unchanged.
- `frame_tick` in the same cycle as DONE is not accepted; it sets `overrun`.
- Reset, including mid-frame: state returns to IDLE, and the counter, checksum and `overrun` clear. Any partial packet already in the FIFO is not retracted.
- Reset values: `ram_re`, `ram_addr`, `fifo_push`, `fifo_wdata`, `busy`, `frame_done` and `overrun` are all 0.
- `fifo_wdata` is 0 whenever `fifo_push` is 0.

## Timing
- An accepted `frame_tick` at cycle 0 with the FIFO not full gives SYNC0 pushed at cycle 1.
- Header is 4 cycles minimum. Each pixel costs 2 cycles minimum (RD, WR).
- Minimum packet time is 4 + 2·FRAME_BYTES + 1 cycles from cycle 1. `frame_done` follows in the next cycle.
- Each cycle with `fifo_full` high stalls HDR*, LEN*, PIX_RD or CSUM by exactly one cycle. PIX_WR never stalls.
- `ram_re` to the `ram_rdata` push is exactly 1 cycle.

## Configuration
- `TX_CHECKSUM_EN` defined: the CSUM state exists, so each packet is FRAME_BYTES+5 bytes.
- `TX_CHECKSUM_EN` undefined:
  - The CSUM state and accumulator are removed.
  - PIX_WR of the last byte goes directly to DONE.
  - Each packet is FRAME_BYTES+4 bytes.

## Structure
- Shared package `uart_tx_pkg` holds:
  - the state enum `tx_ctrl_state_t`;
  - the default `SYNC0`/`SYNC1` constants;
  - `FRAME_BYTES_DEFAULT` = 5160.
- Sub-module `tx_csum_acc`: an 8-bit modulo accumulator with clear/enable, instantiated only under `TX_CHECKSUM_EN`.

## Test plan
- FRAME_BYTES=4, RAM = 01,02,03,04, FIFO never full, pulse `frame_tick` → push sequence AA,55,00,04,01,02,03,04,0A, then a `frame_done` pulse. `ram_addr` runs 0..3.
- `fifo_full` held high for 3 cycles in HDR1 → HDR1 is pushed exactly once, 3 cycles late. Byte order is unchanged.
- `fifo_full` high during PIX_RD of address 2 → no `ram_re` and no push while full. Address 2 is read once after release.
- Second `frame_tick` mid-pixel → `overrun`=1, and the packet completes byte-identical. The next IDLE `frame_tick` clears `overrun`.
- `reset` asserted in PIX_WR → next cycle all outputs are 0 and the state is IDLE. A new `frame_tick` restarts at SYNC0 with a fresh checksum.
- RAM = FF,FF,FF,FF → checksum FC (carry discarded). With `TX_CHECKSUM_EN` undefined → 8 bytes, with `frame_done` right after byte 04.
